// File: rtl/dense_feed_ctrl.sv
// Purpose: buffers one D-element vector, clears the dense layer, replays the vector at 1 element per 2 cycles, then captures and holds the result.
// Latency: CLEAR 1 cycle after the last input beat, then 2*D FEED cycles, then WAIT until dense_valid_i; HOLD starts the next cycle.
// Backpressure: in_ready_o deasserts when the buffer is full or during CLEAR/FEED; out_ready_i low parks the block in HOLD with out_data_o stable.
module dense_feed_ctrl #(
  parameter int D          = 64,
  parameter int B          = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [DATA_WIDTH-1:0]     in_data_i,
  output logic                      dense_rstn_o,
  output logic                      dense_valid_o,
  output logic [DATA_WIDTH-1:0]     dense_data_o,
  input  logic                      dense_valid_i,
  input  logic [DATA_WIDTH*B-1:0]   dense_data_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [DATA_WIDTH*B-1:0]   out_data_o,
  output logic                      err_o
);

  function automatic int clogb2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int AW = (clogb2(D) > 0) ? clogb2(D) : 1;
  localparam int CW = AW + 1;
  localparam int PW = (clogb2(D - 1) > 0) ? clogb2(D - 1) : 1;
  localparam logic [CW-1:0] D_CNT   = CW'(D);
  localparam logic [PW-1:0] LAST_IX = PW'(D - 1);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_WAIT  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  vec_buf [D];
  logic [CW-1:0]          wr_cnt;
  logic [CW-1:0]          wr_cnt_nxt;
  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          rd_nxt;
  logic                   phase;
  logic                   rst_done;
  logic                   load_state;
  logic                   accept;

  // Loading is allowed whenever the buffer is not being replayed; ready is gated until the first edge after reset release.
  assign load_state = (state == S_LOAD) || (state == S_WAIT) || (state == S_HOLD);
  assign in_ready_o = rst_done & load_state & (wr_cnt < D_CNT);
  assign accept     = in_valid_i & in_ready_o;
  assign wr_cnt_nxt = accept ? (wr_cnt + 1'b1) : wr_cnt;
  assign rd_nxt     = rd_ptr + 1'b1;

  // Reset-release flag that keeps in_ready_o low until the clock has ticked once out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rst_done <= 1'b0;
    else       rst_done <= 1'b1;
  end

  // Element storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (accept) vec_buf[wr_cnt[AW-1:0]] <= in_data_i;
  end

  // Sequencer with all outputs registered against the next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= S_LOAD;
      wr_cnt        <= '0;
      rd_ptr        <= '0;
      phase         <= 1'b0;
      dense_rstn_o  <= 1'b0;
      dense_valid_o <= 1'b0;
      dense_data_o  <= '0;
      out_valid_o   <= 1'b0;
      out_data_o    <= '0;
      err_o         <= 1'b0;
    end else begin
      wr_cnt       <= wr_cnt_nxt;
      dense_rstn_o <= 1'b1;

      // A result outside WAIT, or a beat offered into a full buffer while loading, is a protocol fault.
      if ((dense_valid_i && (state != S_WAIT)) ||
          (in_valid_i && (state == S_LOAD) && (wr_cnt == D_CNT))) begin
        err_o <= 1'b1;
      end

      case (state)
        S_LOAD: begin
          if (wr_cnt_nxt == D_CNT) begin
            state        <= S_CLEAR;
            dense_rstn_o <= 1'b0;
          end
        end
        S_CLEAR: begin
          rd_ptr        <= '0;
          phase         <= 1'b0;
          dense_valid_o <= 1'b1;
          dense_data_o  <= vec_buf[0];
          state         <= S_FEED;
        end
        S_FEED: begin
          if (!phase) begin
            phase         <= 1'b1;
            dense_valid_o <= 1'b0;
          end else begin
            phase  <= 1'b0;
            rd_ptr <= rd_nxt;
            if (rd_ptr == LAST_IX) begin
              // Whole vector handed over: the buffer is free for the next one.
              wr_cnt <= '0;
              state  <= S_WAIT;
            end else begin
              dense_valid_o <= 1'b1;
              dense_data_o  <= vec_buf[rd_nxt];
            end
          end
        end
        S_WAIT: begin
          if (dense_valid_i) begin
            out_data_o  <= dense_data_i;
            out_valid_o <= 1'b1;
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            // A vector completed in this same cycle goes straight to the clear.
            if (wr_cnt_nxt == D_CNT) begin
              state        <= S_CLEAR;
              dense_rstn_o <= 1'b0;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_feed_ctrl.sv
// Bench for dense_feed_ctrl: directed vectors with a scoreboard of expected feed elements and results.
// A behavioural dense layer answers each fed vector a few cycles after the last strobe.
// Monitors sample on the falling edge; stimulus changes 1 time unit after the rising edge.
module tb_dense_feed_ctrl;

  localparam int D  = 64;
  localparam int B  = 7;
  localparam int DW = 8;

  typedef logic [DW-1:0] vec_t [D];

  logic               clk = 1'b0;
  logic               rstn;
  logic               in_valid_i;
  logic               in_ready_o;
  logic [DW-1:0]      in_data_i;
  logic               dense_rstn_o;
  logic               dense_valid_o;
  logic [DW-1:0]      dense_data_o;
  logic               dense_valid_i;
  logic [DW*B-1:0]    dense_data_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [DW*B-1:0]    out_data_o;
  logic               err_o;

  int n_checks = 0;
  int n_fail   = 0;
  int ready_mode = 0;
  int inj_req  = 0;
  int inj_done = 0;
  int strobes_in_vec = 0;
  int cyc = 0;

  logic [DW-1:0]   exp_elem [$];
  logic [DW*B-1:0] exp_out  [$];

  dense_feed_ctrl #(.D(D), .B(B), .DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_data_i     (in_data_i),
    .dense_rstn_o  (dense_rstn_o),
    .dense_valid_o (dense_valid_o),
    .dense_data_o  (dense_data_o),
    .dense_valid_i (dense_valid_i),
    .dense_data_i  (dense_data_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_data_o    (out_data_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string why);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s", name, why);
  endtask

  // Reference dense layer: lane k = sum of (element * (k+1)), modulo 2^8.
  function automatic logic [DW*B-1:0] golden(input vec_t v);
    logic [DW*B-1:0] r;
    logic [DW-1:0]   acc;
    r = '0;
    for (int k = 0; k < B; k++) begin
      acc = '0;
      for (int i = 0; i < D; i++) acc = acc + DW'(int'(v[i]) * (k + 1));
      r[k*DW +: DW] = acc;
    end
    return r;
  endfunction

  task automatic check_reset_vals(input string p);
    check({p, "_in_ready"},    64'(in_ready_o),    64'd0);
    check({p, "_dense_rstn"},  64'(dense_rstn_o),  64'd0);
    check({p, "_dense_valid"}, 64'(dense_valid_o), 64'd0);
    check({p, "_dense_data"},  64'(dense_data_o),  64'd0);
    check({p, "_out_valid"},   64'(out_valid_o),   64'd0);
    check({p, "_out_data"},    64'(out_data_o),    64'd0);
    check({p, "_err"},         64'(err_o),         64'd0);
  endtask

  // Called 1 unit after a rising edge; returns 1 unit after the accepting edge.
  task automatic push_beat(input logic [DW-1:0] d, input bit gaps);
    int tmo;
    if (gaps && ($urandom_range(1) == 0)) begin
      in_valid_i = 1'b0;
      @(posedge clk); #1;
    end
    in_valid_i = 1'b1;
    in_data_i  = d;
    tmo = 0;
    do begin
      @(negedge clk);
      tmo++;
    end while (!in_ready_o && tmo < 5000);
    if (tmo >= 5000) fail_now("beat_accept", "in_ready_o never asserted within 5000 cycles");
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic send_vector(input vec_t v, input bit gaps, input logic [DW*B-1:0] res);
    for (int i = 0; i < D; i++) exp_elem.push_back(v[i]);
    exp_out.push_back(res);
    for (int i = 0; i < D; i++) push_beat(v[i], gaps);
  endtask

  task automatic wait_results();
    int tmo;
    tmo = 0;
    while ((exp_out.size() != 0 || out_valid_o) && tmo < 5000) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 5000) fail_now("result_drain", "results still outstanding after 5000 cycles");
    @(posedge clk); #1;
  endtask

  // Skips the CLEAR cycle's falling edge, then polls until enough elements of this vector were fed.
  task automatic wait_strobes(input int n);
    int tmo;
    tmo = 0;
    @(negedge clk);
    do begin
      @(negedge clk);
      tmo++;
    end while (strobes_in_vec < n && tmo < 2000);
    if (tmo >= 2000) fail_now("feed_progress", "feed did not reach the requested element in 2000 cycles");
  endtask

  // Result back-pressure: 0 always ready, 1 held low, 2 random.
  initial begin
    out_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready_i = 1'b1;
        1:       out_ready_i = 1'b0;
        default: out_ready_i = 1'($urandom_range(1));
      endcase
    end
  end

  // Behavioural dense layer plus error-pulse injector.
  initial begin
    vec_t            mv;
    int              mcnt;
    int              mwait;
    logic [DW*B-1:0] mres;
    mcnt = 0;
    mwait = -1;
    mres = '0;
    dense_valid_i = 1'b0;
    dense_data_i  = '0;
    forever begin
      @(negedge clk);
      if (!rstn || !dense_rstn_o) begin
        mcnt = 0;
        if (!rstn) mwait = -1;
      end else if (dense_valid_o) begin
        mv[mcnt] = dense_data_o;
        mcnt++;
        if (mcnt == D) begin
          mres  = golden(mv);
          mwait = 3;
          mcnt  = 0;
        end
      end
      @(posedge clk); #1;
      dense_valid_i = 1'b0;
      if (rstn) begin
        if (inj_req != inj_done) begin
          dense_valid_i = 1'b1;
          dense_data_i  = '1;
          inj_done++;
        end else if (mwait == 0) begin
          dense_valid_i = 1'b1;
          dense_data_i  = mres;
          mwait = -1;
        end else if (mwait > 0) begin
          mwait--;
        end
      end
    end
  end

  // Scoreboard monitor: feed order, strobe spacing, clear width, result values and hold stability.
  initial begin
    int              last_cyc;
    int              low_len;
    bit              prev_hs;
    bit              prev_ov;
    logic [DW*B-1:0] prev_od;
    last_cyc = 0;
    low_len  = 0;
    prev_hs  = 1'b0;
    prev_ov  = 1'b0;
    prev_od  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        exp_elem.delete();
        exp_out.delete();
        strobes_in_vec = 0;
        low_len = 0;
        prev_hs = 1'b0;
        prev_ov = 1'b0;
      end else begin
        if (!dense_rstn_o) begin
          low_len++;
          strobes_in_vec = 0;
        end else if (low_len > 0) begin
          check("clear_width", 64'(low_len), 64'd1);
          low_len = 0;
        end
        if (dense_valid_o) begin
          if (strobes_in_vec > 0) check("strobe_gap", 64'(cyc - last_cyc), 64'd2);
          last_cyc = cyc;
          strobes_in_vec++;
          if (exp_elem.size() == 0)
            fail_now("feed_elem", $sformatf("unexpected element %0h, expected none", dense_data_o));
          else
            check("feed_elem", 64'(dense_data_o), 64'(exp_elem.pop_front()));
        end
        if (prev_hs)
          check("out_valid_drop", 64'(out_valid_o), 64'd0);
        else if (prev_ov && out_valid_o)
          check("out_stable", 64'(out_data_o), 64'(prev_od));
        prev_hs = out_valid_o && out_ready_i;
        if (prev_hs) begin
          if (exp_out.size() == 0)
            fail_now("result", $sformatf("unexpected result %0h, expected none", out_data_o));
          else
            check("result", 64'(out_data_o), 64'(exp_out.pop_front()));
        end
        prev_ov = out_valid_o;
        prev_od = out_data_o;
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    fail_now("watchdog", "bench did not complete within 60000 cycles");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    vec_t va, vb, vc, vd, ve, vf, vr;
    int   tmo;
    in_valid_i = 1'b0;
    in_data_i  = '0;
    rstn       = 1'b0;

    repeat (3) @(posedge clk); #1;
    check_reset_vals("rst");
    @(negedge clk); #2 rstn = 1'b1;
    #1 check("in_ready_before_edge", 64'(in_ready_o), 64'd0);
    @(negedge clk);
    check("in_ready_after_edge", 64'(in_ready_o), 64'd1);
    check("dense_rstn_idle", 64'(dense_rstn_o), 64'd1);
    @(posedge clk); #1;

    // Ramp vector 0x01..0x40; expected lanes hand-computed: sum = 2080 -> 0x20*(k+1) mod 256.
    for (int i = 0; i < D; i++) va[i] = DW'(i + 1);
    send_vector(va, 1'b0, 56'hE0_C0_A0_80_60_40_20);
    wait_results();

    // Result held under back-pressure while the next vector fills the buffer.
    ready_mode = 1;
    for (int i = 0; i < D; i++) vb[i] = DW'(3 * i + 7);
    for (int i = 0; i < D; i++) vc[i] = DW'(255 - 2 * i);
    send_vector(vb, 1'b0, golden(vb));
    tmo = 0;
    do begin
      @(negedge clk);
      tmo++;
    end while (!out_valid_o && tmo < 2000);
    if (tmo >= 2000) fail_now("hold_reach", "out_valid_o never asserted within 2000 cycles");
    @(posedge clk); #1;
    send_vector(vc, 1'b0, golden(vc));
    @(negedge clk);
    check("in_ready_full", 64'(in_ready_o), 64'd0);
    repeat (200) @(negedge clk);
    check("hold_valid", 64'(out_valid_o), 64'd1);
    ready_mode = 0;
    tmo = 0;
    do begin
      @(negedge clk);
      tmo++;
    end while (!(out_valid_o && out_ready_i) && tmo < 100);
    if (tmo >= 100) fail_now("hold_release", "no output handshake within 100 cycles");
    @(negedge clk);
    check("hold_to_clear", 64'(dense_rstn_o), 64'd0);
    wait_results();

    // Stray dense result during FEED sets the sticky error.
    for (int i = 0; i < D; i++) vd[i] = DW'($urandom);
    send_vector(vd, 1'b0, golden(vd));
    wait_strobes(5);
    inj_req++;
    repeat (3) @(negedge clk);
    check("err_set", 64'(err_o), 64'd1);
    wait_results();
    check("err_sticky", 64'(err_o), 64'd1);

    // Reset in the middle of the feed, then a fresh vector from element 0.
    for (int i = 0; i < D; i++) ve[i] = DW'(5 * i + 1);
    send_vector(ve, 1'b0, golden(ve));
    wait_strobes(31);
    #1 rstn = 1'b0;
    #1 check_reset_vals("abort");
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rstn = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < D; i++) vf[i] = DW'(100 + i);
    send_vector(vf, 1'b0, golden(vf));
    wait_results();

    // Back-to-back random vectors with input gaps and random result back-pressure.
    ready_mode = 2;
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < D; i++) vr[i] = DW'($urandom);
      send_vector(vr, 1'b1, golden(vr));
    end
    wait_results();
    ready_mode = 0;

    check("elem_queue_empty", 64'(exp_elem.size()), 64'd0);
    check("err_clean", 64'(err_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dense_feed_ctrl.md
# dense_feed_ctrl

Sequencer that sits in front of one serial dense layer. It buffers a flattened input vector of D activations arriving on a ready/valid stream, clears the dense layer's accumulators, and replays the vector into the layer at the layer's one-element-per-two-cycles rate. It then captures the B-wide result and holds it on a ready/valid output. The next vector may load while the current result is pending.

## Interface
- D, 64: elements per input vector; equals the dense layer's D.
- B, 7: dense layer output width in elements.
- DATA_WIDTH, 8: bits per element, signed.
- clk  in  1  clock; all logic is rising-edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid_i  in  1  input element valid.
- in_ready_o  out  1  input element accepted when in_valid_i & in_ready_o.
- in_data_i  in  DATA_WIDTH  input element; element 0 arrives first.
- dense_rstn_o  out  1  synchronous active-low clear to the dense layer's rstn.
- dense_valid_o  out  1  one-cycle element strobe to the dense layer's valid_i.
- dense_data_o  out  DATA_WIDTH  element to the dense layer's data_i.
- dense_valid_i  in  1  dense layer's valid_o.
- dense_data_i  in  DATA_WIDTH*B  dense layer's data_o.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  result consumed when out_valid_o & out_ready_i.
- out_data_o  out  DATA_WIDTH*B  captured result; lane k is [k*DATA_WIDTH +: DATA_WIDTH].
- err_o  out  1  sticky protocol error flag.

## Operation
- Buffer: D x DATA_WIDTH register array.
  - wr_cnt is clogb2(D)+1 bits, range 0..D.
  - rd_ptr is clogb2(D-1) bits.
- in_ready_o = (state is LOAD, WAIT or HOLD) & (wr_cnt < D).
  - Each accepted beat writes buf[wr_cnt] and increments wr_cnt.
- States:
  - LOAD
    - Entered after reset.
    - Moves to CLEAR in the cycle after wr_cnt reaches D.
  - CLEAR
    - dense_rstn_o=0 for exactly 1 cycle.
    - Clears rd_ptr and phase.
    - Moves to FEED.
  - FEED
    - phase 0: dense_valid_o=1 and dense_data_o=buf[rd_ptr].
    - phase 1: dense_valid_o=0, rd_ptr+1.
    - After phase 1 of element D-1: wr_cnt<=0 and move to WAIT. Buffer writes are allowed from that cycle on.
  - WAIT
    - Stays until dense_valid_i=1.
    - Then out_data_o<=dense_data_i and move to HOLD.
  - HOLD
    - out_valid_o=1.
    - On out_ready_i: move to CLEAR if wr_cnt==D, else LOAD.
- dense_rstn_o is 1 in every state except CLEAR.
- err_o sets on either condition; it is cleared only by rstn:
  - dense_valid_i=1 in any state other than WAIT;
  - in_valid_i=1 with wr_cnt==D in LOAD (cannot occur in-protocol; diagnostic only).
- No arithmetic on data. Elements pass bit-exact; result lanes are unchanged from dense_data_i.

## Timing
- Reset values while rstn=0 (asynchronous):
  - state=LOAD, wr_cnt=0, rd_ptr=0, phase=0.
  - in_ready_o=0 (gated by a registered reset-release flag; becomes 1 on the first clock edge after rstn rises).
  - dense_rstn_o=0, dense_valid_o=0, dense_data_o=0.
  - out_valid_o=0, out_data_o=0, err_o=0.
- All outputs except in_ready_o are registered.
- Strobe spacing: dense_valid_o pulses exactly every 2 cycles, D pulses per vector, never back-to-back.
- Latency from the last accepted input beat:
  - 1 cycle to CLEAR;
  - 2D cycles of FEED;
  - WAIT, then HOLD the cycle after dense_valid_i.
- Mid-FEED stalls: none. FEED ignores out_ready_i and in_valid_i.
- Simultaneous events:
  - In HOLD, an accepted input beat that makes wr_cnt==D in the same cycle as the out handshake takes HOLD -> CLEAR.
  - out_valid_o drops the cycle after the handshake.
- Reset asserted mid-FEED aborts immediately.
  - dense_rstn_o=0 during reset also clears the dense layer.
  - No partial vector survives.
- Back-pressure: out_ready_i held low leaves the block in HOLD indefinitely. out_data_o stays stable and input keeps loading until wr_cnt==D.

## Test plan
- Reset then 64 beats 0x01..0x40 with in_valid_i always 1:
  - dense_rstn_o low for 1 cycle;
  - 64 dense_valid_o pulses 2 cycles apart carrying 0x01..0x40 in order.
- Dense model returns 0x7F80... at the end of WAIT with out_ready_i=1:
  - out_valid_o high 1 cycle;
  - out_data_o equals the returned word.
- out_ready_i held low 200 cycles while a second 64-beat vector streams in:
  - in_ready_o drops after beat 64;
  - out_data_o stable;
  - on release, HOLD -> CLEAR directly.
- Random in_valid_i gaps (50%) and random out_ready_i: every vector is fed in order and results match a golden dense model.
- Pulse dense_valid_i during FEED: err_o=1 and stays 1 until rstn.
- Assert rstn low at FEED element 30:
  - all outputs are at reset values within the same cycle;
  - the next vector is fed from element 0 with a fresh CLEAR.
